// File: rtl/gf_pkg.sv
// Galois-field constants, types and helpers shared by the RS decoder blocks.
// Holds the field parameters, the syndrome root count/offset, the syndrome FSM
// state type, and constant-evaluable GF(2^m) multiply / power-of-alpha helpers.
package gf_pkg;

  localparam int SYMB_WIDTH = 8;
  localparam int POLY       = 285;
  localparam int SYMB_NUM   = 1 << SYMB_WIDTH;
  localparam int K_LEN      = 255;
  localparam int N_LEN      = 239;
  localparam int ROOTS_NUM  = K_LEN - N_LEN;
  localparam int FCR        = 0;

  typedef logic [SYMB_WIDTH-1:0] symb_t;
  typedef symb_t synd_vec_t [ROOTS_NUM-1:0];
  typedef logic [ROOTS_NUM*SYMB_WIDTH-1:0] synd_flat_t;

  typedef enum logic {ACCUM, HOLD} synd_state_t;

  // Reduction term: the primitive polynomial without its x^SYMB_WIDTH bit.
  localparam symb_t POLY_LO = symb_t'(POLY);

  // Shift-and-add multiply. With one operand constant this folds into a pure
  // XOR network.
  function automatic symb_t gf_mult(input symb_t a, input symb_t b);
    symb_t p;
    symb_t aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[SYMB_WIDTH-1] ? ((aa << 1) ^ POLY_LO) : (aa << 1);
    end
    return p;
  endfunction

  function automatic symb_t alpha_to_symb(input int unsigned e);
    symb_t s;
    s = symb_t'(1);
    for (int unsigned i = 0; i < e; i++) s = gf_mult(s, symb_t'(2));
    return s;
  endfunction

  // Root j (alpha^(FCR+j)) lands in bits [j*SYMB_WIDTH +: SYMB_WIDTH].
  function automatic synd_flat_t gen_root_consts();
    synd_flat_t r;
    r = '0;
    for (int j = 0; j < ROOTS_NUM; j++)
      r[j*SYMB_WIDTH +: SYMB_WIDTH] = alpha_to_symb(unsigned'((FCR + j) % (SYMB_NUM - 1)));
    return r;
  endfunction

endpackage

// File: rtl/rs_synd_cell.sv
// One Horner accumulator evaluating the received polynomial at a fixed root.
// Ports: en (symbol accepted), first (restart with this symbol), din (symbol),
//        acc_nxt (value acc takes on an enabled edge), acc (current value).
module rs_synd_cell
  import gf_pkg::*;
#(
  parameter symb_t ROOT_SYMB = symb_t'(1)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  first,
  input  logic [SYMB_WIDTH-1:0] din,
  output logic [SYMB_WIDTH-1:0] acc_nxt,
  output logic [SYMB_WIDTH-1:0] acc
);

  // No reset needed: the first symbol of every codeword overwrites acc.
  assign acc_nxt = first ? din : (gf_mult(acc, ROOT_SYMB) ^ din);

  always_ff @(posedge clk) begin
    if (en) acc <= acc_nxt;
  end

endmodule

// File: rtl/rs_syndrome.sv
// Streaming RS syndrome calculator: one symbol per cycle in, one syndrome vector
// per codeword out. Ports: clk/rst (sync, active-high), s_valid/s_ready/s_data/
// s_last symbol stream, m_valid/m_ready/m_synd/m_err/m_len_err vector output.
module rs_syndrome
  import gf_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [SYMB_WIDTH-1:0]           s_data,
  input  logic                            s_last,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [ROOTS_NUM*SYMB_WIDTH-1:0] m_synd,
  output logic                            m_err,
  output logic                            m_len_err
);

  localparam int CNT_W = $clog2(K_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(K_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_LEN - 1);
  localparam synd_flat_t ROOT_CONSTS = gen_root_consts();

  synd_state_t state, state_nxt;
  logic        first;
  logic [CNT_W-1:0] count;
  logic        pend_len_err;
  logic        xfer;
  logic        out_free;
  logic        load_out;
  logic        from_hold;
  logic        len_bad;
  synd_vec_t   acc;
  synd_vec_t   acc_nxt;
  synd_flat_t  new_synd;
  logic        new_len_err;

  for (genvar j = 0; j < ROOTS_NUM; j++) begin : g_cell
    rs_synd_cell #(
      .ROOT_SYMB(ROOT_CONSTS[j*SYMB_WIDTH +: SYMB_WIDTH])
    ) u_cell (
      .clk    (clk),
      .en     (xfer),
      .first  (first),
      .din    (s_data),
      .acc_nxt(acc_nxt[j]),
      .acc    (acc[j])
    );
  end

  assign xfer     = s_valid && s_ready;
  assign out_free = !m_valid || m_ready;
  assign len_bad  = (count != CNT_LAST);

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    load_out  = 1'b0;
    from_hold = 1'b0;
    case (state)
      ACCUM: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          if (out_free) load_out  = 1'b1;
          else          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (m_valid && m_ready) begin
          load_out  = 1'b1;
          from_hold = 1'b1;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Direct loads must include the symbol on this edge (acc_nxt); a held
  // codeword already sits in the accumulators.
  always_comb begin
    new_synd = '0;
    for (int j = 0; j < ROOTS_NUM; j++)
      new_synd[j*SYMB_WIDTH +: SYMB_WIDTH] = from_hold ? acc[j] : acc_nxt[j];
    new_len_err = from_hold ? pend_len_err : len_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCUM;
      first        <= 1'b1;
      count        <= '0;
      pend_len_err <= 1'b0;
      m_valid      <= 1'b0;
      m_synd       <= '0;
      m_err        <= 1'b0;
      m_len_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        first <= s_last;
        if (s_last)              count <= '0;
        else if (count != CNT_MAX) count <= count + 1'b1;
        if (s_last) pend_len_err <= len_bad;
      end
      if (load_out) begin
        m_valid   <= 1'b1;
        m_synd    <= new_synd;
        m_err     <= |new_synd;
        m_len_err <= new_len_err;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs_syndrome.sv
// Bench for rs_syndrome: directed codewords, a reference syndrome model by
// direct polynomial evaluation with log/antilog tables, and an RS encoder for
// valid codewords. Expected vectors are queued at drive time, popped on output.
module tb_rs_syndrome;
  import gf_pkg::*;

  localparam int SW = ROOTS_NUM * SYMB_WIDTH;
  localparam int CW = SW + 2;
  localparam int NQ = SYMB_NUM - 1;

  typedef struct packed {
    logic [SW-1:0] synd;
    logic          err;
    logic          len_err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  symb_t         s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [SW-1:0] m_synd;
  logic          m_err;
  logic          m_len_err;

  rs_syndrome dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_synd   (m_synd),
    .m_err    (m_err),
    .m_len_err(m_len_err)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_bad = 0;
  exp_t  sb[$];
  symb_t cw[$];
  int    gexp[0:2*NQ-1];
  int    glog[0:NQ];
  int    gpoly[0:ROOTS_NUM];

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[glog[a] + glog[b]];
  endfunction

  // S_j = sum_i cw[i] * alpha^((FCR+j)*(n-1-i))
  function automatic exp_t model(input int n);
    exp_t e;
    int   s;
    e.synd = '0;
    for (int j = 0; j < ROOTS_NUM; j++) begin
      s = 0;
      for (int i = 0; i < n; i++)
        if (cw[i] != 0)
          s = s ^ gexp[(glog[cw[i]] + ((FCR + j) * (n - 1 - i)) % NQ) % NQ];
      e.synd[j*SYMB_WIDTH +: SYMB_WIDTH] = symb_t'(s);
    end
    e.err     = |e.synd;
    e.len_err = (n != K_LEN);
    return e;
  endfunction

  task automatic make_random(input int n);
    cw.delete();
    for (int i = 0; i < n; i++) cw.push_back(symb_t'($urandom_range(0, NQ)));
  endtask

  task automatic make_zero(input int n);
    cw.delete();
    for (int i = 0; i < n; i++) cw.push_back('0);
  endtask

  // Systematic encoder: random message, parity = m(x)*x^R mod g(x).
  task automatic make_valid();
    int par[0:ROOTS_NUM-1];
    int fb;
    int m;
    cw.delete();
    for (int k = 0; k < ROOTS_NUM; k++) par[k] = 0;
    for (int i = 0; i < K_LEN - ROOTS_NUM; i++) begin
      m = $urandom_range(0, NQ);
      cw.push_back(symb_t'(m));
      fb = m ^ par[ROOTS_NUM-1];
      for (int k = ROOTS_NUM - 1; k >= 1; k--) par[k] = par[k-1] ^ gmul(fb, gpoly[k]);
      par[0] = gmul(fb, gpoly[0]);
    end
    for (int k = ROOTS_NUM - 1; k >= 0; k--) cw.push_back(symb_t'(par[k]));
  endtask

  // Drives cw[0..n-1]; returns #1 after the edge that took the last symbol.
  task automatic send(input int n, input bit with_last, input bit is_codeword);
    exp_t e;
    int   to;
    if (with_last) begin
      if (is_codeword) begin
        e.synd = '0; e.err = 1'b0; e.len_err = 1'b0;
      end else begin
        e = model(n);
      end
      sb.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = cw[i];
      s_last  = with_last && (i == n - 1);
      to = 0;
      while (!s_ready && to < 2000) begin
        @(posedge clk); #1;
        to++;
      end
      if (to >= 2000) begin
        chk1("s_ready_wait", s_ready, 1'b1);
        break;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Output checker: pops on every handshake, verifies stability while stalled.
  exp_t held_v;
  bit   held = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk1("stall_valid", m_valid, 1'b1);
        chk("stall_stable", {m_synd, m_err, m_len_err}, held_v);
      end
      if (m_valid && m_ready) begin
        chk1("vector_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("vector", {m_synd, m_err, m_len_err}, e);
        end
      end
      held   = m_valid && !m_ready;
      held_v = {m_synd, m_err, m_len_err};
    end
  end

  initial begin
    int x;
    int to;
    logic [SW-1:0] ones;

    x = 1;
    glog[0] = 0;
    for (int i = 0; i < NQ; i++) begin
      gexp[i]      = x;
      gexp[i + NQ] = x;
      glog[x]      = i;
      x = x << 1;
      if (x >= SYMB_NUM) x = x ^ POLY;
    end
    for (int k = 0; k <= ROOTS_NUM; k++) gpoly[k] = 0;
    gpoly[0] = 1;
    for (int j = 0; j < ROOTS_NUM; j++) begin
      for (int k = j + 1; k >= 1; k--)
        gpoly[k] = gpoly[k-1] ^ gmul(gpoly[k], gexp[(FCR + j) % NQ]);
      gpoly[0] = gmul(gpoly[0], gexp[(FCR + j) % NQ]);
    end
    ones = '0;
    for (int j = 0; j < ROOTS_NUM; j++) ones[j*SYMB_WIDTH +: SYMB_WIDTH] = 8'h01;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk1("rst_s_ready", s_ready, 1'b1);
    chk1("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_synd", CW'(m_synd), '0);
    chk1("rst_m_err", m_err, 1'b0);
    chk1("rst_m_len_err", m_len_err, 1'b0);

    // All-zero codeword: vector visible right after the s_last edge
    make_zero(K_LEN);
    send(K_LEN, 1'b1, 1'b0);
    chk1("zero_latency", m_valid, 1'b1);
    chk("zero_synd", CW'(m_synd), '0);
    chk1("zero_err", m_err, 1'b0);
    chk1("zero_len_err", m_len_err, 1'b0);

    // Only the last (degree-0) symbol set: every S_j = 1
    make_zero(K_LEN);
    cw[K_LEN-1] = 8'h01;
    send(K_LEN, 1'b1, 1'b0);
    chk("lastone_synd", CW'(m_synd), CW'(ones));
    chk1("lastone_err", m_err, 1'b1);

    // Only the first symbol set: S_j = alpha^(254*j)
    make_zero(K_LEN);
    cw[0] = 8'h01;
    send(K_LEN, 1'b1, 1'b0);
    chk("firstone_s0", CW'(m_synd[7:0]), CW'(8'h01));
    chk("firstone_s1", CW'(m_synd[15:8]), CW'(8'h8E));

    // Three back-to-back codewords against a stalled consumer
    @(posedge clk); #1;
    m_ready = 1'b0;
    fork
      begin
        make_valid();
        send(K_LEN, 1'b1, 1'b1);
        make_random(K_LEN);
        send(K_LEN, 1'b1, 1'b0);
        make_valid();
        send(K_LEN, 1'b1, 1'b1);
      end
      begin
        repeat (600) @(posedge clk);
        #1;
        chk1("hold_s_ready", s_ready, 1'b0);
        chk1("hold_m_valid", m_valid, 1'b1);
        m_ready = 1'b1;
      end
    join

    // Short codeword, then an overlong one
    make_random(10);
    cw[0] = 8'h5A;
    send(10, 1'b1, 1'b0);
    chk1("short_len_err", m_len_err, 1'b1);
    make_random(260);
    send(260, 1'b1, 1'b0);
    chk1("long_len_err", m_len_err, 1'b1);

    // Reset in the middle of a codeword, then a clean one
    repeat (3) @(posedge clk);
    #1;
    make_random(K_LEN);
    send(100, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("midrst_m_valid", m_valid, 1'b0);
    chk1("midrst_s_ready", s_ready, 1'b1);
    make_random(K_LEN);
    send(K_LEN, 1'b1, 1'b0);

    to = 0;
    while (sb.size() != 0 && to < 1000) begin
      @(posedge clk); #1;
      to++;
    end
    chk1("scoreboard_drained", sb.size() == 0, 1'b1);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
